// File: rtl/stage_queue_pkg.sv
// rtl/stage_queue_pkg.sv - shared pipeline lane-count types and constants
package stage_queue_pkg;

    // Widest pipeline boundary supported by the fetch/decode/issue queues.
    localparam int MAX_WAYS   = 4;
    localparam int LANE_CNT_W = $clog2(MAX_WAYS + 1);
    localparam int LANE_IDX_W = $clog2(MAX_WAYS);

    typedef logic [LANE_CNT_W-1:0] lane_cnt_t;
    typedef logic [LANE_IDX_W-1:0] lane_idx_t;

endpackage

// File: rtl/stage_queue_if.sv
// rtl/stage_queue_if.sv - multi-lane push/pop handshake bundle for stage_queue
interface stage_queue_if #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int WAYS  = 2
);
    logic [WAYS-1:0]              in_valid;
    logic [WAYS*WIDTH-1:0]        in_data;
    logic                         in_ready;
    logic [WAYS-1:0]              out_valid;
    logic [WAYS*WIDTH-1:0]        out_data;
    logic [WAYS-1:0]              out_ready;
    logic [$clog2(DEPTH+1)-1:0]   count;

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    // Queue side.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/stage_queue_lane_prefix_cnt.sv
// rtl/stage_queue_lane_prefix_cnt.sv - length of the contiguous run of set bits from lane 0
module lane_prefix_cnt
    import stage_queue_pkg::*;
#(
    parameter int WAYS = 2
) (
    input  logic [WAYS-1:0] i_mask,
    output lane_cnt_t       o_cnt
);

    logic w_run;

    // Count lanes until the first clear bit; anything above it is ignored.
    always_comb begin
        o_cnt = '0;
        w_run = 1'b1;
        for (int i = 0; i < WAYS; i++) begin
            if (w_run && i_mask[i]) begin
                o_cnt = o_cnt + lane_cnt_t'(1);
            end else begin
                w_run = 1'b0;
            end
        end
    end

endmodule

// File: rtl/stage_queue.sv
// rtl/stage_queue.sv - multi-way in-order queue between pipeline stages
module stage_queue
    import stage_queue_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8,
    parameter int WAYS  = 2
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          flush,
    stage_queue_if.slave  q
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]       r_rd_ptr;
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [CNT_W-1:0]       r_count;
    logic [WIDTH-1:0]       r_mem [DEPTH];

    logic                   w_in_ready;
    logic                   w_discard;
    logic [WAYS-1:0]        w_out_valid;
    logic [WAYS-1:0]        w_pop_mask;
    logic [WAYS*WIDTH-1:0]  w_out_data;
    lane_cnt_t              w_push_req;
    lane_cnt_t              w_push_cnt;
    lane_cnt_t              w_pop_cnt;

    // Room for a whole group is judged from registered occupancy only.
    assign w_in_ready = (r_count <= CNT_W'(DEPTH - WAYS));
    assign w_discard  = reset_ | flush;

    // Present the oldest entries lane by lane straight from storage.
    always_comb begin
        w_out_valid = '0;
        w_out_data  = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_out_valid[i]               = (r_count > CNT_W'(i));
            w_out_data[i*WIDTH +: WIDTH] = r_mem[r_rd_ptr + PTR_W'(i)];
        end
    end

    assign w_pop_mask = w_out_valid & q.out_ready;

    lane_prefix_cnt #(.WAYS(WAYS)) u_push_cnt (
        .i_mask (q.in_valid),
        .o_cnt  (w_push_req)
    );

    lane_prefix_cnt #(.WAYS(WAYS)) u_pop_cnt (
        .i_mask (w_pop_mask),
        .o_cnt  (w_pop_cnt)
    );

    assign w_push_cnt = w_in_ready ? w_push_req : '0;

    // Pointer and occupancy update; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (w_discard) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_push_cnt);
            r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop_cnt);
            r_count  <= r_count + CNT_W'(w_push_cnt) - CNT_W'(w_pop_cnt);
        end
    end

    // Write accepted lanes at consecutive slots; contents are never cleared.
    always_ff @(posedge clk) begin
        if (!w_discard) begin
            for (int i = 0; i < WAYS; i++) begin
                if (i < int'(w_push_cnt)) begin
                    r_mem[r_wr_ptr + PTR_W'(i)] <= q.in_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign q.in_ready  = w_in_ready;
    assign q.out_valid = w_out_valid;
    assign q.out_data  = w_out_data;
    assign q.count     = r_count;

endmodule

// File: doc/stage_queue.md
STAGE_QUEUE -- requirements
Module: stage_queue

Interface
REQ-001 SHALL have parameter WIDTH, default 64, payload bits per lane.
REQ-002 SHALL have parameter DEPTH, default 8, entry count (power of two, DEPTH >= 2*WAYS).
REQ-003 SHALL have parameter WAYS, default 2, lanes pushed/popped per cycle (1..4).
REQ-004 SHALL have port clk  in  1  sole clock; one clock, all state on rising edge.
REQ-005 SHALL have port reset_  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port flush  in  1  discard all held and incoming entries.
REQ-007 SHALL have port in_valid  in  WAYS  per-lane push request, lane 0 oldest.
REQ-008 SHALL have port in_data  in  WAYS*WIDTH  lane i at bits [i*WIDTH +: WIDTH].
REQ-009 SHALL have port in_ready  out  1  queue accepts a full WAYS-lane group this cycle.
REQ-010 SHALL have port out_valid  out  WAYS  lane i holds the i-th oldest entry.
REQ-011 SHALL have port out_data  out  WAYS*WIDTH  oldest entries, same lane packing.
REQ-012 SHALL have port out_ready  in  WAYS  per-lane consumer acceptance.
REQ-013 SHALL have port count  out  $clog2(DEPTH+1)  current occupancy.

Function
REQ-014 Accepted push lanes SHALL be the contiguous prefix of in_valid from lane 0; lanes above the first 0 ignored.
REQ-015 Push SHALL occur only when in_ready=1; in_ready = (DEPTH - count >= WAYS), derived from registered state only (no path from out_ready/in_valid).
REQ-016 Lane i pushed SHALL be written at wr_ptr+i mod DEPTH; wr_ptr advances by push count.
REQ-017 out_valid[i] SHALL equal (count > i); out_data lane i SHALL be entry rd_ptr+i mod DEPTH, combinational read of storage.
REQ-018 Popped lanes SHALL be the contiguous prefix where out_valid[i] & out_ready[i]; lanes above first failing lane not popped.
REQ-019 Push-to-out_valid latency SHALL be 1 cycle; no same-cycle bypass.
REQ-020 Simultaneous push and pop SHALL update count by push_cnt - pop_cnt in one cycle; full queue with pop does not raise in_ready until next cycle.
REQ-021 Pointers SHALL wrap modulo DEPTH; entry order preserved across wrap.
REQ-022 flush=1 SHALL zero count, rd_ptr, wr_ptr next cycle; pushes and pops in the flush cycle are discarded.
REQ-023 out_data of lanes with out_valid=0 SHALL be don't-care; storage contents not reset.
REQ-024 Pop on a lane with out_valid=0 SHALL be ignored without state change.

Reset
REQ-025 reset_=1 SHALL produce count=0, rd_ptr=0, wr_ptr=0, out_valid=0, in_ready=1 on next edge.
REQ-026 Reset mid-operation SHALL discard all entries identically to flush; reset dominates flush.

Structure
REQ-027 WAYS/lane-count typedef and lane-index width constants SHALL reside in the shared CPU pipeline package for reuse by fetch/decode/issue boundaries.
REQ-028 Contiguous-prefix counting (REQ-014, REQ-018) SHALL be a sub-module lane_prefix_cnt, instantiated twice.
REQ-029 Storage SHALL be a flat register array with WAYS write and WAYS read ports; no SRAM macro.

Verification (WIDTH=64, DEPTH=8, WAYS=2)
REQ-030 Reset, then in_valid=2'b11 data {A,B} -> next cycle out_valid=2'b11, out_data lane0=A lane1=B, count=2.
REQ-031 Push 4 groups, no pop -> count=8, in_ready=0; 5th group not stored; pop 2 -> in_ready=1 one cycle later.
REQ-032 in_valid=2'b10 -> nothing pushed, count unchanged; out_ready=2'b10 with out_valid=2'b11 -> no pop.
REQ-033 Continuous push/pop 2 per cycle for 20 cycles -> count stays 2, data order preserved across 5 pointer wraps.
REQ-034 count=6 with flush=1 and concurrent push 2'b11 -> next cycle count=0, out_valid=0, in_ready=1.
REQ-035 count=4, reset_ asserted during push+pop -> next cycle count=0, out_valid=0; subsequent push of C -> out lane0=C.
